button_press_gen: RTL
=====================

# button_press_gen

Generates synthetic pushbutton activity: each one-cycle request pulse becomes one active-low "press" of fixed length followed by a fixed release gap, with requests queued while a press is in progress. It drives the same active-low button signal that the press detector consumes, so the computer's front panel can be stepped automatically (test harnesses, auto-run) without a human at the board. Idle output level is 1 (not pressed).

## Interface
- `PRESS_CYCLES`, default 4: cycles `button_out` is held low per press; must be ≥1.
- `GAP_CYCLES`, default 4: cycles `button_out` is held high after each press before the next press may start; must be ≥1.
- `MAX_PENDING`, default 3: maximum number of queued requests not yet started; must be ≥1.
- `clock`  in  1  System clock.
- `reset`  in  1  Reset, asynchronous, active-low.
- `pulse_in`  in  1  Press request; sampled on every rising edge; each high cycle is one request.
- `button_out`  out  1  Synthetic button, active-low (0 = pressed, 1 = not pressed).
- `busy`  out  1  High when the state is not IDLE.
- `pending`  out  $clog2(MAX_PENDING+1)  Count of queued, not-yet-started requests.
- `overflow`  out  1  One-cycle pulse when a request is dropped because the queue is full.

## Operation
- States: IDLE, PRESS, GAP. Encoding is a shared constant.
- All outputs are registered or decoded from registered state.
  - `button_out` = (state != PRESS).
  - `busy` = (state != IDLE).
- Reset values: state IDLE, `button_out` 1, `busy` 0, `pending` 0, `overflow` 0, timer 0.
- IDLE:
  - If `pending` > 0: go to PRESS and decrement `pending`.
  - Else if `pulse_in`: go to PRESS; the request is consumed directly and `pending` is unchanged.
- PRESS: the timer counts PRESS_CYCLES cycles, then the state goes to GAP.
- GAP: the timer counts GAP_CYCLES cycles. On the last GAP cycle:
  - If `pending` > 0: go to PRESS and decrement `pending`.
  - Else if `pulse_in`: go to PRESS.
  - Else: go to IDLE.
- Queueing rules:
  - A `pulse_in` that is not consumed directly increments `pending`.
  - Simultaneous increment and dequeue leaves `pending` unchanged.
  - If `pending` == MAX_PENDING, `pulse_in` is high, and no dequeue occurs that cycle, the request is dropped. `overflow` goes high for the next cycle only and `pending` stays at MAX_PENDING.
- The timer is $clog2(max(PRESS_CYCLES,GAP_CYCLES)+1) bits wide. It reloads on every state entry and never wraps.
- Every accepted request yields exactly one low interval on `button_out`. Dropped requests yield none.

## Timing
- Request latency: with `pulse_in` sampled high at edge t in IDLE (queue empty), `button_out` goes 0 after edge t and returns to 1 after edge t+PRESS_CYCLES.
- Back-to-back presses: the next press starts after edge t+PRESS_CYCLES+GAP_CYCLES. No IDLE cycle is inserted.
- `busy` falls after edge t+PRESS_CYCLES+GAP_CYCLES when no further work exists.
- Loopback: a press detector on `button_out` emits its one-cycle pulse one cycle after the press ends. The minimum GAP of 1 still lets it return to its free state before the next press.
- Reset mid-operation: `button_out` returns to 1 asynchronously. `pending` and the timer clear and the queue is lost. No partial press resumes after reset is released.
- A `pulse_in` held high for N cycles counts as N requests.

## Structure
- Shared package: the state encoding constants (IDLE/PRESS/GAP) and the default parameter values, shared with the press detector's test bench.
- One natural sub-module: `cycle_timer`, a loadable down-counter with a `done` flag, used for both the PRESS and GAP intervals. The queue counter stays inline.

## Test plan
All scenarios use PRESS_CYCLES=4, GAP_CYCLES=4, MAX_PENDING=3 unless noted.
- Reset: assert `reset`=0 → `button_out`=1, `busy`=0, `pending`=0, `overflow`=0; values hold for 10 cycles after release with `pulse_in`=0.
- Single request: `pulse_in` high for 1 cycle at edge 0 → `button_out`=0 after edges 0–3, 1 after edge 4; `busy` falls after edge 8; a loopback press detector emits exactly one pulse.
- Burst: `pulse_in` high for 5 consecutive cycles → first press starts immediately; `pending` climbs 1,2,3; the 5th request produces one `overflow` cycle; exactly 4 presses result, each 4 low cycles and 4 high cycles apart; `pending` ends at 0.
- Chain without idle: `pulse_in` high on the last GAP cycle with `pending`=0 → the next PRESS starts on the following edge with no IDLE cycle and `busy` never drops.
- Full queue with dequeue: `pending`=3 and `pulse_in` on the GAP-exit edge → request accepted, `pending` stays 3, `overflow` stays 0.
- Reset mid-press: assert `reset` during the 2nd PRESS cycle with `pending`=2 → `button_out`=1 immediately and `pending`=0; a single request after release produces a normal 4-cycle press.

Source files
------------

// File: rtl/button_press_gen_pkg.sv
// Shared definitions for the synthetic pushbutton generator and the press
// detector bench: state encoding and default timing parameters.
package button_press_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int DEF_PRESS_CYCLES = 4;
  localparam int DEF_GAP_CYCLES   = 4;
  localparam int DEF_MAX_PENDING  = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_press_gen_if.sv
// Request/status bundle between a press requester (master) and the
// synthetic button generator (slave).
interface button_press_gen_if
  import button_press_gen_pkg::*;
#(
  parameter int MAX_PENDING = DEF_MAX_PENDING
);
  localparam int PW = $clog2(MAX_PENDING + 1);

  logic          pulse_in;
  logic          button_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  modport master (output pulse_in, input button_out, busy, pending, overflow);
  modport slave  (input pulse_in, output button_out, busy, pending, overflow);
endinterface

// File: rtl/button_press_gen_cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// It saturates at zero rather than wrapping.
module cycle_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);
  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign done = (count_q == '0);
endmodule

// File: rtl/button_press_gen.sv
// Synthetic active-low pushbutton: each accepted request becomes one press
// of PRESS_CYCLES followed by a GAP_CYCLES release, with a bounded queue.
module button_press_gen
  import button_press_gen_pkg::*;
#(
  parameter int PRESS_CYCLES = DEF_PRESS_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int MAX_PENDING  = DEF_MAX_PENDING
) (
  input logic                clock,
  input logic                reset,
  button_press_gen_if.slave  bus
);
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int TW = $clog2(max_int(PRESS_CYCLES, GAP_CYCLES) + 1);
  localparam logic [TW-1:0] PRESS_LOAD = TW'(PRESS_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX   = PW'(MAX_PENDING);

  state_t        state_q, state_d;
  logic [PW-1:0] pending_q, pending_d;
  logic          overflow_q, overflow_d;
  logic          timer_load;
  logic [TW-1:0] timer_value;
  logic          timer_done;
  logic          have_pending;
  logic          start_press;
  logic          dequeue;
  logic          direct;
  logic          enqueue;

  cycle_timer #(.WIDTH(TW)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_load   = 1'b0;
    timer_value  = '0;
    start_press  = 1'b0;
    pending_d    = pending_q;
    overflow_d   = 1'b0;
    have_pending = (pending_q != '0);

    case (state_q)
      ST_IDLE:  start_press = have_pending || bus.pulse_in;
      ST_PRESS: begin
        if (timer_done) begin
          state_d     = ST_GAP;
          timer_load  = 1'b1;
          timer_value = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (timer_done) begin
          if (have_pending || bus.pulse_in) start_press = 1'b1;
          else                              state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_press) begin
      state_d     = ST_PRESS;
      timer_load  = 1'b1;
      timer_value = PRESS_LOAD;
    end

    // A queued request always wins the start slot; the live pulse only
    // starts a press directly when nothing is waiting.
    dequeue = start_press && have_pending;
    direct  = start_press && !have_pending;
    enqueue = bus.pulse_in && !direct;

    if (enqueue && !dequeue) begin
      if (pending_q == PEND_MAX) overflow_d = 1'b1;
      else                       pending_d  = pending_q + PW'(1);
    end else if (dequeue && !enqueue) begin
      pending_d = pending_q - PW'(1);
    end
  end

  assign bus.button_out = (state_q != ST_PRESS);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.pending    = pending_q;
  assign bus.overflow   = overflow_q;
endmodule
